model_cpu8: RTL and testbench

- 8-bit accumulator-style model computer: four 8-bit general registers, a 16-op instruction set, flags Z/C, and an internal 256x8 unified program/data RAM.
- Instructions execute in a fixed 8-state one-hot timing ring (T0..T7).
- Sits under the board top; T drives LED[15:8]; AX/DX feed BCD converters and 7-seg display; HALT gates the external clock divider.

---
 rtl/model_cpu8.sv | 267 ++++++++++++++++++++++++++
 tb/tb_model_cpu8.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/model_cpu8.sv
// model_cpu8: 8-bit accumulator-style model computer.
// Four 8-bit registers, 16-op instruction set, Z/C flags and a 256x8 unified
// program/data memory. Each instruction runs through a one-hot T0..T7 ring.
module model_cpu8 (
  input  logic       clk,
  input  logic       RESET,
  input  logic       RUN,
  output logic [7:0] AX,
  output logic [7:0] DX,
  output logic [7:0] R,
  output logic [7:0] ABUS,
  output logic [7:0] DBUS,
  output logic [7:0] D2BUS,
  output logic [7:0] T,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  output logic [7:0] PC2MAR,
  output logic [7:0] IROUT,
  output logic [3:0] IRX,
  output logic [1:0] DST,
  output logic [1:0] SRC,
  output logic       HALT
);

  localparam logic [7:0] T0 = 8'b0000_0001;
  localparam logic [7:0] T1 = 8'b0000_0010;
  localparam logic [7:0] T2 = 8'b0000_0100;
  localparam logic [7:0] T3 = 8'b0000_1000;
  localparam logic [7:0] T4 = 8'b0001_0000;
  localparam logic [7:0] T5 = 8'b0010_0000;
  localparam logic [7:0] T6 = 8'b0100_0000;
  localparam logic [7:0] T7 = 8'b1000_0000;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_INC = 4'h7;
  localparam logic [3:0] OP_DEC = 4'h8;
  localparam logic [3:0] OP_MVI = 4'h9;
  localparam logic [3:0] OP_LDA = 4'hA;
  localparam logic [3:0] OP_STA = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_JC  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [7:0]      t_q, t_d;
  logic [7:0]      pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [7:0]      mar_q, mar_d;
  logic [7:0]      r_q, r_d;
  logic [7:0]      alu_a_q, alu_a_d;
  logic [7:0]      alu_b_q, alu_b_d;
  logic [7:0]      opr_q, opr_d;
  logic [3:0][7:0] regs_q, regs_d;
  logic            z_q, z_d;
  logic            c_q, c_d;
  logic            halt_q, halt_d;

  // Stored bytes live in ram_q; wr_q marks which bytes have been stored since
  // power-up. Unwritten bytes read the hard-coded program image. Neither is
  // reset, so stores survive a CPU reset.
  logic [7:0]      ram_q [256];
  logic [255:0]    wr_q;
  logic            mem_we;
  logic [7:0]      mem_rdata;

  logic [3:0]      op;
  logic [1:0]      dst;
  logic [1:0]      src;
  logic            two_byte;
  logic            alu_op;
  logic            adv;
  logic [8:0]      alu_sum;
  logic [7:0]      alu_res;
  logic            alu_c;

  // Power-up program image.
  function automatic logic [7:0] rom_byte(input logic [7:0] addr);
    case (addr)
      8'h00:   rom_byte = 8'h90;
      8'h01:   rom_byte = 8'h00;
      8'h02:   rom_byte = 8'h9C;
      8'h03:   rom_byte = 8'h05;
      8'h04:   rom_byte = 8'h23;
      8'h05:   rom_byte = 8'h8C;
      8'h06:   rom_byte = 8'hD0;
      8'h07:   rom_byte = 8'h0A;
      8'h08:   rom_byte = 8'hC0;
      8'h09:   rom_byte = 8'h04;
      8'h0A:   rom_byte = 8'hB0;
      8'h0B:   rom_byte = 8'h80;
      8'h0C:   rom_byte = 8'hF0;
      default: rom_byte = 8'h00;
    endcase
  endfunction

  assign op        = ir_q[7:4];
  assign dst       = ir_q[3:2];
  assign src       = ir_q[1:0];
  assign two_byte  = (op >= OP_MVI) && (op <= OP_JC);
  assign alu_op    = (op >= OP_ADD) && (op <= OP_DEC);
  assign adv       = RUN && !halt_q;
  assign mem_rdata = wr_q[mar_q] ? ram_q[mar_q] : rom_byte(mar_q);

  // ALU result and carry/borrow from the operands latched at T2.
  always_comb begin
    alu_sum = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_sum = {1'b0, alu_a_q} + {1'b0, alu_b_q};
        alu_res = alu_sum[7:0];
        alu_c   = alu_sum[8];
      end
      OP_SUB: begin
        alu_sum = {1'b0, alu_a_q} - {1'b0, alu_b_q};
        alu_res = alu_sum[7:0];
        alu_c   = alu_sum[8];
      end
      OP_AND: alu_res = alu_a_q & alu_b_q;
      OP_OR:  alu_res = alu_a_q | alu_b_q;
      OP_NOT: alu_res = ~alu_a_q;
      OP_INC: begin
        alu_sum = {1'b0, alu_a_q} + 9'd1;
        alu_res = alu_sum[7:0];
        alu_c   = alu_sum[8];
      end
      OP_DEC: begin
        alu_sum = {1'b0, alu_a_q} - 9'd1;
        alu_res = alu_sum[7:0];
        alu_c   = alu_sum[8];
      end
      default: ;
    endcase
  end

  // Per-state datapath actions and timing ring advance.
  always_comb begin
    t_d     = t_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mar_d   = mar_q;
    r_d     = r_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    opr_d   = opr_q;
    regs_d  = regs_q;
    z_d     = z_q;
    c_d     = c_q;
    halt_d  = halt_q;
    mem_we  = 1'b0;
    if (adv) begin
      t_d = {t_q[6:0], t_q[7]};
      case (t_q)
        T0: mar_d = pc_q;
        T1: begin
          ir_d = mem_rdata;
          pc_d = pc_q + 8'd1;
        end
        T2: begin
          alu_a_d = regs_q[dst];
          alu_b_d = regs_q[src];
          if (two_byte) mar_d = pc_q;
        end
        T3: begin
          if (alu_op) begin
            r_d = alu_res;
            z_d = (alu_res == 8'h00);
            c_d = alu_c;
          end else if (op == OP_MOV) begin
            r_d = alu_b_q;
          end
          if (two_byte) begin
            opr_d = mem_rdata;
            pc_d  = pc_q + 8'd1;
          end
        end
        T4: begin
          case (op)
            OP_MVI:         regs_d[dst] = opr_q;
            OP_JMP:         pc_d = opr_q;
            OP_JZ:          if (z_q) pc_d = opr_q;
            OP_JC:          if (c_q) pc_d = opr_q;
            OP_LDA, OP_STA: mar_d = opr_q;
            OP_NOP, OP_HLT: ;
            default:        regs_d[dst] = r_q;
          endcase
        end
        T5: begin
          case (op)
            OP_LDA: regs_d[dst] = mem_rdata;
            OP_STA: mem_we = 1'b1;
            OP_HLT: begin
              halt_d = 1'b1;
              t_d    = T5;
            end
            default: ;
          endcase
        end
        T6, T7: ;
        default: t_d = T0;
      endcase
    end
  end

  // CPU state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      t_q     <= T0;
      pc_q    <= '0;
      ir_q    <= '0;
      mar_q   <= '0;
      r_q     <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      opr_q   <= '0;
      regs_q  <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      t_q     <= t_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mar_q   <= mar_d;
      r_q     <= r_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      opr_q   <= opr_d;
      regs_q  <= regs_d;
      z_q     <= z_d;
      c_q     <= c_d;
      halt_q  <= halt_d;
    end
  end

  // STA write port into data memory.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      ram_q[mar_q] <= regs_q[src];
      wr_q[mar_q]  <= 1'b1;
    end
  end

  assign AX     = regs_q[0];
  assign DX     = regs_q[3];
  assign R      = r_q;
  assign ABUS   = mar_q;
  assign DBUS   = mem_rdata;
  assign D2BUS  = regs_q[src];
  assign T      = t_q;
  assign ALU_A  = alu_a_q;
  assign ALU_B  = alu_b_q;
  assign PC2MAR = pc_q;
  assign IROUT  = ir_q;
  assign IRX    = ir_q[7:4];
  assign DST    = ir_q[3:2];
  assign SRC    = ir_q[1:0];
  assign HALT   = halt_q;

endmodule

// File: tb/tb_model_cpu8.sv
// Scoreboard bench for model_cpu8: an instruction-level reference model fills
// a queue of architectural states; a monitor pops one per completed instruction.
module tb_model_cpu8;
  logic       clk;
  logic       RESET;
  logic       RUN;
  logic [7:0] AX, DX, R, ABUS, DBUS, D2BUS, T, ALU_A, ALU_B, PC2MAR, IROUT;
  logic [3:0] IRX;
  logic [1:0] DST, SRC;
  logic       HALT;

  model_cpu8 dut (
    .clk(clk), .RESET(RESET), .RUN(RUN),
    .AX(AX), .DX(DX), .R(R), .ABUS(ABUS), .DBUS(DBUS), .D2BUS(D2BUS),
    .T(T), .ALU_A(ALU_A), .ALU_B(ALU_B), .PC2MAR(PC2MAR), .IROUT(IROUT),
    .IRX(IRX), .DST(DST), .SRC(SRC), .HALT(HALT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ax;
    logic [7:0] dx;
    logic [7:0] pc;
    logic       z;
    logic       c;
    logic       halt;
  } arch_t;

  localparam int unsigned NO_HALT = 1000000;

  arch_t       exp_q[$];
  logic [7:0]  img [256];
  logic [7:0]  model_mem [256];
  int unsigned halt_clk = NO_HALT;
  int unsigned en_cnt = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  bit          mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: executes img and queues the state after each instruction.
  task automatic run_model();
    logic [7:0]  m [256];
    logic [7:0]  rg [4];
    logic [7:0]  pc, ir, opr, a, b;
    logic [3:0]  op;
    logic [1:0]  d, s;
    logic        z, c;
    int unsigned x, n;
    arch_t       e;
    m = img;
    for (int i = 0; i < 4; i++) rg[i] = 8'h00;
    pc = 8'h00; z = 1'b0; c = 1'b0; n = 0; opr = 8'h00;
    exp_q.delete();
    halt_clk = NO_HALT;
    for (int k = 0; k < 2000; k++) begin
      ir = m[pc];
      pc = pc + 8'd1;
      op = ir[7:4]; d = ir[3:2]; s = ir[1:0];
      a = rg[d]; b = rg[s];
      if (op >= 4'h9 && op <= 4'hE) begin
        opr = m[pc];
        pc  = pc + 8'd1;
      end
      case (op)
        4'h1: rg[d] = b;
        4'h2: begin x = 32'(a) + 32'(b); c = (x > 255); rg[d] = x[7:0]; end
        4'h3: begin x = 32'(a) - 32'(b); c = (a < b);   rg[d] = x[7:0]; end
        4'h4: begin rg[d] = a & b; c = 1'b0; end
        4'h5: begin rg[d] = a | b; c = 1'b0; end
        4'h6: begin rg[d] = ~a;    c = 1'b0; end
        4'h7: begin c = (a == 8'hFF); rg[d] = a + 8'd1; end
        4'h8: begin c = (a == 8'h00); rg[d] = a - 8'd1; end
        4'h9: rg[d] = opr;
        4'hA: rg[d] = m[opr];
        4'hB: m[opr] = b;
        4'hC: pc = opr;
        4'hD: if (z) pc = opr;
        4'hE: if (c) pc = opr;
        default: ;
      endcase
      if (op >= 4'h2 && op <= 4'h8) z = (rg[d] == 8'h00);
      n++;
      e = '{ax: rg[0], dx: rg[3], pc: pc, z: z, c: c, halt: (op == 4'hF)};
      exp_q.push_back(e);
      if (op == 4'hF) begin
        halt_clk = 8 * (n - 1) + 6;
        break;
      end
    end
    model_mem = m;
  endtask

  // Monitor: counts enabled clocks, checks the ring and pops one entry per instruction.
  initial begin : monitor
    bit         on, adv;
    arch_t      e;
    logic [7:0] one;
    one = 8'h01;
    forever begin
      @(posedge clk);
      on  = mon_on;
      adv = on && RESET && RUN && (en_cnt < halt_clk);
      #3;
      if (!on) begin
        en_cnt = 0;
      end else begin
        if (adv) begin
          en_cnt++;
          if ((en_cnt % 8 == 0) || (en_cnt == halt_clk)) begin
            if (exp_q.size() == 0) begin
              chk("scoreboard_underflow", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("sb_ax", AX, e.ax);
              chk("sb_dx", DX, e.dx);
              chk("sb_pc", PC2MAR, e.pc);
              chk("sb_z", dut.z_q, e.z);
              chk("sb_c", dut.c_q, e.c);
              chk("sb_halt", HALT, e.halt);
            end
          end
        end
        if (en_cnt < halt_clk) begin
          chk("t_ring", T, one << (en_cnt % 8));
        end else begin
          chk("t_halted", T, 8'h20);
          chk("halt_flag", HALT, 1);
        end
      end
    end
  end

  task automatic clocks(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_dut_image();
    for (int i = 0; i < 256; i++) begin
      dut.ram_q[i] = img[i];
      dut.wr_q[i]  = 1'b1;
    end
  endtask

  task automatic start_prog(input bit load);
    RUN    = 1'b0;
    mon_on = 1'b0;
    clocks(1);
    RESET = 1'b0;
    if (load) load_dut_image();
    clocks(2);
    RESET = 1'b1;
    run_model();
    clocks(1);
    mon_on = 1'b1;
  endtask

  // Runs until the model's halt point plus a few extra clocks, optionally stalling RUN.
  task automatic run_to_halt(input bit stall, input int unsigned start_sent);
    int unsigned sent, cyc;
    sent = start_sent;
    cyc  = 0;
    while (cyc < 3000 && !(sent >= halt_clk && sent - halt_clk >= 8)) begin
      RUN = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      clocks(1);
      cyc++;
      if (RUN) sent++;
    end
    RUN = 1'b0;
    clocks(2);
    chk("halt_reached", HALT, 1);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic default_image();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    img[8'h00] = 8'h90; img[8'h01] = 8'h00; img[8'h02] = 8'h9C; img[8'h03] = 8'h05;
    img[8'h04] = 8'h23; img[8'h05] = 8'h8C; img[8'h06] = 8'hD0; img[8'h07] = 8'h0A;
    img[8'h08] = 8'hC0; img[8'h09] = 8'h04; img[8'h0A] = 8'hB0; img[8'h0B] = 8'h80;
    img[8'h0C] = 8'hF0;
  endtask

  task automatic random_image();
    int unsigned a, kind;
    logic [1:0]  d, s;
    logic [3:0]  op;
    for (int i = 0; i < 256; i++) img[i] = (i >= 192) ? 8'($urandom) : 8'h00;
    a = 0;
    for (int k = 0; k < 14; k++) begin
      kind = $urandom_range(0, 5);
      d = 2'($urandom_range(0, 3));
      s = 2'($urandom_range(0, 3));
      case (kind)
        0: begin img[a] = {4'h9, d, 2'b00}; img[a + 1] = 8'($urandom); a += 2; end
        1, 2: begin op = 4'($urandom_range(1, 8)); img[a] = {op, d, s}; a += 1; end
        3: begin img[a] = {4'hB, 2'b00, s}; img[a + 1] = {2'b11, 6'($urandom)}; a += 2; end
        4: begin img[a] = {4'hA, d, 2'b00}; img[a + 1] = {2'b11, 6'($urandom)}; a += 2; end
        default: begin
          img[a]     = ($urandom_range(0, 1) == 0) ? 8'hD0 : 8'hE0;
          img[a + 1] = 8'(a + 3);
          img[a + 2] = {4'h7, d, 2'b00};
          a += 3;
        end
      endcase
    end
    img[a] = 8'hF0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    RUN   = 1'b0;
    RESET = 1'b1;
    #2 RESET = 1'b0;
    #1;
    chk("rst_t", T, 8'h01);
    chk("rst_pc", PC2MAR, 8'h00);
    chk("rst_ax", AX, 8'h00);
    chk("rst_dx", DX, 8'h00);
    chk("rst_halt", HALT, 0);
    chk("rst_ir", IROUT, 8'h00);
    clocks(3);
    chk("rst_held_t", T, 8'h01);
    RESET = 1'b1;
    clocks(1);
    chk("rel_t", T, 8'h01);
    chk("rel_pc", PC2MAR, 8'h00);
    chk("rel_ir", IROUT, 8'h00);

    // Default program from the built-in image, with a 50-clock freeze mid-run.
    default_image();
    run_model();
    mon_on = 1'b1;
    clocks(1);
    RUN = 1'b1;
    clocks(2);
    chk("fetch1_ir", IROUT, 8'h90);
    chk("fetch1_irx", IRX, 4'h9);
    chk("fetch1_dst", DST, 2'd0);
    chk("fetch1_src", SRC, 2'd0);
    chk("fetch1_pc", PC2MAR, 8'h01);
    clocks(8);
    chk("fetch2_ir", IROUT, 8'h9C);
    chk("fetch2_pc", PC2MAR, 8'h03);
    clocks(3);
    chk("mvi_dx", DX, 8'h05);
    chk("mvi_t5", T, 8'h20);
    chk("mvi_pc", PC2MAR, 8'h04);
    clocks(47);
    RUN = 1'b0;
    clocks(50);
    chk("frz_t", T, 8'h10);
    chk("frz_ax", AX, 8'h09);
    chk("frz_dx", DX, 8'h04);
    chk("frz_r", R, 8'h03);
    chk("frz_pc", PC2MAR, 8'h06);
    run_to_halt(1'b1, 60);
    chk("def_ax", AX, 8'h0F);
    chk("def_dx", DX, 8'h00);
    chk("def_mem80", dut.ram_q[8'h80], 8'h0F);
    chk("def_z", dut.z_q, 1);
    chk("def_t", T, 8'h20);
    RUN = 1'b1;
    clocks(20);
    RUN = 1'b0;
    chk("post_ax", AX, 8'h0F);
    chk("post_pc", PC2MAR, 8'h0D);
    chk("post_t", T, 8'h20);

    // Reset while halted, then an uninterrupted rerun.
    RUN    = 1'b1;
    mon_on = 1'b0;
    clocks(1);
    RESET = 1'b0;
    #1;
    chk("rerun_rst_t", T, 8'h01);
    chk("rerun_rst_halt", HALT, 0);
    RUN = 1'b0;
    clocks(2);
    RESET = 1'b1;
    run_model();
    clocks(1);
    mon_on = 1'b1;
    RUN = 1'b1;
    clocks(184);
    RUN = 1'b0;
    chk("rerun_ax", AX, 8'h0F);
    chk("rerun_halt", HALT, 1);
    clocks(1);

    // ADD AX,AX with AX=80.
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    img[0] = 8'h90; img[1] = 8'h80; img[2] = 8'h20; img[3] = 8'hF0;
    start_prog(1'b1);
    run_to_halt(1'b0, 0);
    chk("add_ax", AX, 8'h00);
    chk("add_z", dut.z_q, 1);
    chk("add_c", dut.c_q, 1);

    // SUB AX,BX with AX=01, BX=02.
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    img[0] = 8'h90; img[1] = 8'h01; img[2] = 8'h94; img[3] = 8'h02;
    img[4] = 8'h31; img[5] = 8'hF0;
    start_prog(1'b1);
    run_to_halt(1'b1, 0);
    chk("sub_ax", AX, 8'hFF);
    chk("sub_c", dut.c_q, 1);
    chk("sub_z", dut.z_q, 0);

    // Random straight-line programs with loads, stores and conditional skips.
    for (int p = 0; p < 4; p++) begin
      random_image();
      start_prog(1'b1);
      run_to_halt(1'b1, 0);
      for (int i = 192; i < 256; i++) chk("rand_mem", dut.ram_q[i], model_mem[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
